mmio_bus_controller: RTL and testbench
======================================

Name: mmio_bus_controller

Overview:
- Registered memory-mapped I/O controller between the CPU data port and all data-side slaves: data memory, single-word I/O registers (key, switch, nn_start, nn_read, ...) and the VGA frame window.
- Generalises combinational address decoding with a parametrised count of I/O registers and a parametrised VGA window.
- Adds a request/acknowledge handshake, read-data return muxing, an unmapped-address error and a slave timeout.

Parameters:
- DATA_MEM_CAPACITY, 100: words of data memory, at addresses 0..DATA_MEM_CAPACITY-1.
- NUM_IO, 4: single-word I/O registers, at addresses DATA_MEM_CAPACITY..DATA_MEM_CAPACITY+NUM_IO-1.
- VGA_DEPTH, 2048: words in the VGA window, which starts at VGA_BASE = DATA_MEM_CAPACITY+NUM_IO.
- LOCAL_AW, 11: width of the slave-local offset; must satisfy 2^LOCAL_AW >= max(DATA_MEM_CAPACITY, VGA_DEPTH).
- TIMEOUT, 15: maximum cycles to wait for a slave ack; 1..255.
- NUM_SLOTS, NUM_IO+2 (derived, not overridable): slot 0 = data mem; slots 1..NUM_IO = I/O; slot NUM_IO+1 = VGA.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  access request, sampled in IDLE only
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  word address
- cpu_wdata  in  32  write data
- cpu_ready  out  1  one-cycle pulse: access complete
- cpu_rdata  out  32  read data, valid while cpu_ready=1
- cpu_err  out  1  with cpu_ready: unmapped address or timeout
- dev_req  out  NUM_SLOTS  one-hot slave request, held until ack or timeout
- dev_we  out  1  registered copy of cpu_we
- dev_addr  out  LOCAL_AW  slave-local offset (addr minus slot base)
- dev_wdata  out  32  registered copy of cpu_wdata
- dev_ack  in  NUM_SLOTS  per-slave acknowledge
- dev_rdata  in  32*NUM_SLOTS  flattened read data; slot k occupies bits [32k+31:32k]
- sel_idx  out  $clog2(NUM_SLOTS+1)  slot of the current access; NUM_SLOTS = unmapped

Behaviour:
- Reset (async, resetn=0): state=IDLE; all outputs 0; timeout counter 0.
- IDLE, cpu_req=1:
  - Latch addr/we/wdata.
  - Decode using 32-bit unsigned compares:
    - addr < DATA_MEM_CAPACITY: slot 0.
    - addr < VGA_BASE: slot 1+(addr-DATA_MEM_CAPACITY).
    - addr < VGA_BASE+VGA_DEPTH: VGA slot.
    - otherwise: unmapped.
  - dev_addr = addr minus slot base, truncated to LOCAL_AW; it is 0 for I/O slots.
  - Mapped access: go to ACCESS, assert dev_req bit and sel_idx next cycle, clear counter.
  - Unmapped access: go to RESP with err=1 and rdata=0; no dev_req is issued.
- ACCESS:
  - dev_req held stable; counter increments each cycle.
  - dev_ack of the selected slot = 1: capture that slot's dev_rdata (writes capture 0), drop dev_req next edge, go to RESP with err=0.
  - Acks on non-selected slots are ignored.
  - Counter reaches TIMEOUT without ack: drop dev_req, go to RESP with err=1, rdata=0xDEADBEEF.
- RESP:
  - cpu_ready=1 for exactly one cycle, with cpu_rdata/cpu_err valid.
  - Then return to IDLE; cpu_rdata/cpu_err return to 0.
- Latency:
  - Ack in the first ACCESS cycle: cpu_ready 3 cycles after the req edge.
  - Unmapped: cpu_ready 2 cycles after the req edge.
- Requests:
  - cpu_req outside IDLE is ignored; the CPU holds it until cpu_ready.
  - A new request may be accepted in the cycle after RESP.
  - Back-to-back requests must not leave dev_req asserted for the old slot.
- Ack timing: an ack arriving in the same cycle the counter hits TIMEOUT wins and gives a normal response.
- Boundaries:
  - addr = VGA_BASE+VGA_DEPTH-1 maps to VGA with offset VGA_DEPTH-1.
  - addr = VGA_BASE+VGA_DEPTH is unmapped.
  - addr = 0xFFFFFFFF is unmapped; there is no wrap-around.
- Reset mid-access: all state cleared immediately; dev_req drops asynchronously; no cpu_ready is issued.

Test Plan:
- Defaults, read addr 5, slot 0 acks in the first ACCESS cycle with 0x1234: dev_req=0b000001, dev_addr=5, cpu_ready at cycle 3, cpu_rdata=0x1234, err=0.
- Write addr 102 (nn_start): dev_req bit 3, dev_we=1, dev_addr=0, dev_wdata=cpu_wdata. Read addr 103: bit 4, sel_idx=4.
- VGA edges: addr 104 gives dev_addr 0. Addr 2151 gives dev_addr 2047 with slot 5. Addr 2152 and addr 0xFFFFFFFF give cpu_err=1 at cycle 2 with no dev_req pulse.
- Slave never acks, TIMEOUT=15: dev_req high exactly 15 cycles, then cpu_ready with err=1 and rdata=0xDEADBEEF. A second run acks on cycle 15 and must complete with err=0.
- Stray ack on slot 2 during a slot-0 access: ignored, no early ready. cpu_req held during ACCESS: only one transaction. Back-to-back reads of addr 100 and addr 101 complete in order.
- resetn low during ACCESS: dev_req=0 immediately, no cpu_ready. After release, a fresh read of addr 0 completes normally.

Source files
------------

// File: rtl/mmio_bus_controller.sv
// rtl/mmio_bus_controller.sv - registered MMIO decoder with req/ack handshake, read-data return, unmapped error and slave timeout
module mmio_bus_controller #(
    parameter int DATA_MEM_CAPACITY = 100,
    parameter int NUM_IO            = 4,
    parameter int VGA_DEPTH         = 2048,
    parameter int LOCAL_AW          = 11,
    parameter int TIMEOUT           = 15,
    localparam int NUM_SLOTS        = NUM_IO + 2,
    localparam int SEL_W            = $clog2(NUM_SLOTS + 1)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    output logic                      cpu_ready,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_err,
    output logic [NUM_SLOTS-1:0]      dev_req,
    output logic                      dev_we,
    output logic [LOCAL_AW-1:0]       dev_addr,
    output logic [31:0]               dev_wdata,
    input  logic [NUM_SLOTS-1:0]      dev_ack,
    input  logic [32*NUM_SLOTS-1:0]   dev_rdata,
    output logic [SEL_W-1:0]          sel_idx
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Window boundaries as 32-bit unsigned values so decoding never wraps
    localparam logic [31:0] MEM_END  = 32'(DATA_MEM_CAPACITY);
    localparam logic [31:0] VGA_BASE = 32'(DATA_MEM_CAPACITY + NUM_IO);
    localparam logic [31:0] VGA_END  = 32'(DATA_MEM_CAPACITY + NUM_IO + VGA_DEPTH);

    localparam logic [SEL_W-1:0] SEL_UNMAPPED = SEL_W'(NUM_SLOTS);
    localparam logic [SEL_W-1:0] SEL_VGA      = SEL_W'(NUM_SLOTS - 1);

    // The counter runs 0..TIMEOUT-1 inside ACCESS, so ACCESS lasts at most TIMEOUT cycles
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             cnt_q;

    logic                   dec_mapped;
    logic [SEL_W-1:0]       dec_sel;
    logic [LOCAL_AW-1:0]    dec_off;
    logic [NUM_SLOTS-1:0]   dec_onehot;

    logic                   ack_hit;
    logic [31:0]            ack_data;
    logic                   timed_out;

    // Address decode of the live CPU address into slot, local offset and one-hot request
    always_comb begin
        dec_mapped = 1'b0;
        dec_sel    = SEL_UNMAPPED;
        dec_off    = '0;
        dec_onehot = '0;
        if (cpu_addr < MEM_END) begin
            dec_mapped = 1'b1;
            dec_sel    = '0;
            dec_off    = cpu_addr[LOCAL_AW-1:0];
        end else if (cpu_addr < VGA_BASE) begin
            // Single-word I/O registers have no internal offset
            dec_mapped = 1'b1;
            dec_sel    = SEL_W'(cpu_addr - MEM_END) + SEL_W'(1);
        end else if (cpu_addr < VGA_END) begin
            dec_mapped = 1'b1;
            dec_sel    = SEL_VGA;
            dec_off    = LOCAL_AW'(cpu_addr - VGA_BASE);
        end
        for (int k = 0; k < NUM_SLOTS; k++) begin
            dec_onehot[k] = dec_mapped && (dec_sel == SEL_W'(k));
        end
    end

    // Ack and read data of the selected slave; dev_req is one-hot, so it masks out stray acks
    always_comb begin
        ack_hit  = |(dev_ack & dev_req);
        ack_data = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (dev_req[k]) begin
                ack_data = dev_rdata[32*k +: 32];
            end
        end
        timed_out = (cnt_q == TIMEOUT_LAST);
    end

    // Next-state logic; an ack in the last allowed cycle beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d = dec_mapped ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (ack_hit || timed_out) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slave-side request registers and timeout counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dev_req   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            sel_idx   <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        dev_req   <= dec_onehot;
                        dev_we    <= cpu_we;
                        dev_addr  <= dec_off;
                        dev_wdata <= cpu_wdata;
                        sel_idx   <= dec_sel;
                        cnt_q     <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (ack_hit || timed_out) begin
                        dev_req <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // CPU response registers: loaded only on entry to RESP, so they pulse for exactly one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req && !dec_mapped) begin
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (ack_hit) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= dev_we ? 32'd0 : ack_data;
                    end else if (timed_out) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= TIMEOUT_DATA;
                        cpu_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// tb/tb_mmio_bus_controller.sv - randomized self-checking bench for mmio_bus_controller
module tb_mmio_bus_controller;

    localparam int DMC = 100;
    localparam int NIO = 4;
    localparam int VD  = 2048;
    localparam int LAW = 11;
    localparam int TO  = 15;
    localparam int NS  = NIO + 2;
    localparam int SW  = $clog2(NS + 1);

    logic              clk;
    logic              resetn;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;
    logic [NS-1:0]     dev_req;
    logic              dev_we;
    logic [LAW-1:0]    dev_addr;
    logic [31:0]       dev_wdata;
    logic [NS-1:0]     dev_ack;
    logic [32*NS-1:0]  dev_rdata;
    logic [SW-1:0]     sel_idx;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_bus_controller #(
        .DATA_MEM_CAPACITY(DMC),
        .NUM_IO(NIO),
        .VGA_DEPTH(VD),
        .LOCAL_AW(LAW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err),
        .dev_req(dev_req),
        .dev_we(dev_we),
        .dev_addr(dev_addr),
        .dev_wdata(dev_wdata),
        .dev_ack(dev_ack),
        .dev_rdata(dev_rdata),
        .sel_idx(sel_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference address map: slot and local offset straight from the window layout
    function automatic void ref_map(input logic [31:0] a, output bit mapped, output int slot, output int off);
        longint unsigned la;
        la     = longint'(a);
        mapped = 1'b1;
        slot   = NS;
        off    = 0;
        if (la < DMC) begin
            slot = 0;
            off  = int'(la);
        end else if (la < DMC + NIO) begin
            slot = 1 + int'(la - DMC);
        end else if (la < DMC + NIO + VD) begin
            slot = NIO + 1;
            off  = int'(la - DMC - NIO);
        end else begin
            mapped = 1'b0;
        end
    endfunction

    // One CPU transaction with a behavioural slave. ack_cycle = ACCESS cycle (1-based) in which
    // the selected slave acks, 0 = never. stray = another slot acking throughout, -1 = none.
    // Cycles are numbered with the request cycle as 1. Entered and left at a falling edge.
    task automatic run_txn(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                           input int ack_cycle, input logic [31:0] ack_val, input int stray);
        bit          mapped;
        int          slot;
        int          off;
        int          exp_lat;
        int          exp_req;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [NS-1:0] onehot;
        int          req_cycles;
        int          bad_req;
        int          ready_c;
        logic [31:0] got_rd;
        logic        got_err;

        ref_map(addr, mapped, slot, off);
        onehot = '0;
        if (!mapped) begin
            exp_lat = 2; exp_req = 0; exp_rd = 32'd0; exp_err = 1'b1;
        end else begin
            onehot[slot] = 1'b1;
            if (ack_cycle >= 1 && ack_cycle <= TO) begin
                exp_lat = ack_cycle + 2; exp_req = ack_cycle;
                exp_rd  = we ? 32'd0 : ack_val; exp_err = 1'b0;
            end else begin
                exp_lat = TO + 2; exp_req = TO;
                exp_rd  = 32'hDEADBEEF; exp_err = 1'b1;
            end
        end

        for (int k = 0; k < NS; k++) dev_rdata[32*k +: 32] = $urandom();
        if (mapped) dev_rdata[32*slot +: 32] = ack_val;
        dev_ack   = '0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;

        ready_c = 0; req_cycles = 0; bad_req = 0; got_rd = '0; got_err = 1'b0;
        for (int cyc = 2; cyc <= 40 && ready_c == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                if (mapped) begin
                    check_eq("dev_req_onehot", dev_req, onehot);
                    check_eq("sel_idx", sel_idx, slot);
                    check_eq("dev_addr", dev_addr, off);
                    check_eq("dev_we", dev_we, we);
                    check_eq("dev_wdata", dev_wdata, wdata);
                end else begin
                    check_eq("sel_idx_unmapped", sel_idx, NS);
                    check_eq("dev_req_unmapped", dev_req, 0);
                end
            end
            if (dev_req != '0) begin
                req_cycles++;
                if (dev_req != onehot) bad_req++;
            end
            dev_ack = '0;
            if (cpu_ready) begin
                ready_c = cyc;
                got_rd  = cpu_rdata;
                got_err = cpu_err;
                cpu_req = 1'b0;
            end else begin
                if (mapped && (cyc - 1) == ack_cycle) dev_ack[slot] = 1'b1;
                if (stray >= 0 && stray < NS && stray != slot && dev_req != '0) dev_ack[stray] = 1'b1;
            end
        end
        cpu_req = 1'b0;
        dev_ack = '0;

        check_eq("ready_cycle", ready_c, exp_lat);
        check_eq("cpu_rdata", got_rd, exp_rd);
        check_eq("cpu_err", got_err, exp_err);
        check_eq("dev_req_cycles", req_cycles, exp_req);
        check_eq("dev_req_wrong_slot", bad_req, 0);

        @(negedge clk);
        check_eq("ready_pulse_end", {cpu_ready, cpu_err, cpu_rdata}, 34'd0);
        check_eq("dev_req_idle", dev_req, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        int rdy;
        int sel;
        logic [31:0] a;
        logic [31:0] edges [6];

        resetn    = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dev_ack   = '0;
        dev_rdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_cpu", {cpu_ready, cpu_err, cpu_rdata}, 34'd0);
        check_eq("rst_dev_req", dev_req, 0);
        check_eq("rst_dev_misc", {dev_we, dev_addr, dev_wdata}, 0);
        check_eq("rst_sel_idx", sel_idx, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases
        run_txn(32'd5, 1'b0, 32'h0, 1, 32'h1234, -1);
        run_txn(32'd102, 1'b1, 32'hCAFE_F00D, 1, 32'h5555_AAAA, -1);
        run_txn(32'd103, 1'b0, 32'h0, 2, 32'h0BAD_F00D, -1);
        run_txn(32'd104, 1'b0, 32'h0, 1, 32'h0000_0104, -1);
        run_txn(32'd2151, 1'b0, 32'h0, 3, 32'h0000_2151, -1);
        run_txn(32'd2152, 1'b0, 32'h0, 1, 32'h1111_1111, -1);
        run_txn(32'hFFFF_FFFF, 1'b1, 32'h2222, 1, 32'h2222_2222, -1);
        run_txn(32'd7, 1'b0, 32'h0, 0, 32'h3333_3333, -1);
        run_txn(32'd7, 1'b0, 32'h0, TO, 32'h4444_4444, -1);
        run_txn(32'd0, 1'b0, 32'h0, TO + 1, 32'h5555_5555, -1);
        run_txn(32'd1, 1'b0, 32'h0, 3, 32'h6666_6666, 2);
        run_txn(32'd100, 1'b0, 32'h0, 1, 32'h0000_0100, -1);
        run_txn(32'd101, 1'b0, 32'h0, 1, 32'h0000_0101, -1);

        // Reset in the middle of an access
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'd5;
        dev_ack  = '0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_dev_req", dev_req, 6'b000001);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_dev_req", dev_req, 0);
        check_eq("async_rst_ready", cpu_ready, 0);
        cpu_req = 1'b0;
        rdy = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready) rdy++;
        end
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready) rdy++;
        end
        check_eq("no_ready_after_rst", rdy, 0);
        run_txn(32'd0, 1'b0, 32'h0, 1, 32'h0000_0ABC, -1);

        // Randomized traffic
        edges[0] = 32'd99;   edges[1] = 32'd100;  edges[2] = 32'd103;
        edges[3] = 32'd104;  edges[4] = 32'd2151; edges[5] = 32'd2152;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       a = $urandom_range(0, DMC - 1);
                1:       a = $urandom_range(DMC, DMC + NIO - 1);
                2:       a = $urandom_range(DMC + NIO, DMC + NIO + VD - 1);
                3:       a = edges[$urandom_range(0, 5)];
                4:       a = $urandom();
                default: a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            run_txn(a, 1'($urandom_range(0, 1)), $urandom(), int'($urandom_range(0, TO + 2)),
                    $urandom(), int'($urandom_range(0, 7)) - 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
